fc_argmax_reader: RTL and testbench

- Consumer side of the 10-lane FC output accumulator bank in the LeNet5 final layer.
- On a start pulse it snapshots the ten FC results, so the accumulators can be reset or re-biased immediately afterwards.
- It then scans the snapshot sequentially, one comparison per cycle, and finds the winning class.
- The class index and maximum value are presented on a valid/ready result handshake.

---
 rtl/fc_argmax_reader_if.sv | 33 +++
 rtl/fc_argmax_reader.sv | 113 +++++++++++
 tb/tb_fc_argmax_reader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_argmax_reader_if.sv
// rtl/fc_argmax_reader_if.sv - start/result handshake and FC input lanes of the argmax reader
interface fc_argmax_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] Data_in_1;
  logic [DATA_WIDTH-1:0] Data_in_2;
  logic [DATA_WIDTH-1:0] Data_in_3;
  logic [DATA_WIDTH-1:0] Data_in_4;
  logic [DATA_WIDTH-1:0] Data_in_5;
  logic [DATA_WIDTH-1:0] Data_in_6;
  logic [DATA_WIDTH-1:0] Data_in_7;
  logic [DATA_WIDTH-1:0] Data_in_8;
  logic [DATA_WIDTH-1:0] Data_in_9;
  logic [DATA_WIDTH-1:0] Data_in_10;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [3:0]            class_idx;
  logic [DATA_WIDTH-1:0] max_value;

  modport master (
    output start, Data_in_1, Data_in_2, Data_in_3, Data_in_4, Data_in_5,
           Data_in_6, Data_in_7, Data_in_8, Data_in_9, Data_in_10, res_ready,
    input  busy, res_valid, class_idx, max_value
  );

  modport slave (
    input  start, Data_in_1, Data_in_2, Data_in_3, Data_in_4, Data_in_5,
           Data_in_6, Data_in_7, Data_in_8, Data_in_9, Data_in_10, res_ready,
    output busy, res_valid, class_idx, max_value
  );
endinterface

// File: rtl/fc_argmax_reader.sv
// rtl/fc_argmax_reader.sv - snapshots ten FC results and scans them for the winning class
module fc_argmax_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ARITH_TYPE = 1
) (
  input  logic                clk,
  input  logic                reset,
  fc_argmax_reader_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] snap_q [10];
  logic [DATA_WIDTH-1:0] run_max_q;
  logic [3:0]            run_idx_q;
  logic [3:0]            cnt_q;
  logic                  busy_q;
  logic                  res_valid_q;
  logic [3:0]            class_idx_q;
  logic [DATA_WIDTH-1:0] max_value_q;

  logic [DATA_WIDTH-1:0] data_in [10];
  logic                  upd;
  logic [DATA_WIDTH-1:0] run_max_d;
  logic [3:0]            run_idx_d;

  assign data_in[0] = bus.Data_in_1;
  assign data_in[1] = bus.Data_in_2;
  assign data_in[2] = bus.Data_in_3;
  assign data_in[3] = bus.Data_in_4;
  assign data_in[4] = bus.Data_in_5;
  assign data_in[5] = bus.Data_in_6;
  assign data_in[6] = bus.Data_in_7;
  assign data_in[7] = bus.Data_in_8;
  assign data_in[8] = bus.Data_in_9;
  assign data_in[9] = bus.Data_in_10;

  // Strict greater-than; binary16 is ordered sign-magnitude with +0 == -0.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (ARITH_TYPE != 0) return $signed(a) > $signed(b);
    if (ma == '0 && mb == '0) return 1'b0;
    if (!sa && !sb) return ma > mb;
    if (sa && sb) return ma < mb;
    return !sa;
  endfunction

  always_comb begin
    upd       = greater(snap_q[cnt_q], run_max_q);
    run_max_d = upd ? snap_q[cnt_q] : run_max_q;
    run_idx_d = upd ? cnt_q : run_idx_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < 10; i++) snap_q[i] <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      class_idx_q <= '0;
      max_value_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 10; i++) snap_q[i] <= data_in[i];
            run_max_q <= data_in[0];
            run_idx_q <= 4'd0;
            cnt_q     <= 4'd1;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          run_max_q <= run_max_d;
          run_idx_q <= run_idx_d;
          cnt_q     <= cnt_q + 4'd1;
          // Last lane: publish the updated running max directly.
          if (cnt_q == 4'd9) begin
            state_q     <= RESULT;
            res_valid_q <= 1'b1;
            class_idx_q <= run_idx_d;
            max_value_q <= run_max_d;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.class_idx = class_idx_q;
  assign bus.max_value = max_value_q;
endmodule

// File: tb/tb_fc_argmax_reader.sv
// tb/tb_fc_argmax_reader.sv - scoreboard bench for fixed-point and binary16 argmax readers
module tb_fc_argmax_reader;
  typedef logic [15:0] vec_t [10];
  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_q [$];

  fc_argmax_reader_if #(.DATA_WIDTH(16)) fx_bus ();
  fc_argmax_reader_if #(.DATA_WIDTH(16)) fp_bus ();

  fc_argmax_reader #(.DATA_WIDTH(16), .ARITH_TYPE(1)) u_fx (
    .clk(clk), .reset(reset), .bus(fx_bus.slave)
  );
  fc_argmax_reader #(.DATA_WIDTH(16), .ARITH_TYPE(0)) u_fp (
    .clk(clk), .reset(reset), .bus(fp_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_valid(input bit sel);
    return sel ? fp_bus.res_valid : fx_bus.res_valid;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? fp_bus.busy : fx_bus.busy;
  endfunction
  function automatic logic [3:0] get_idx(input bit sel);
    return sel ? fp_bus.class_idx : fx_bus.class_idx;
  endfunction
  function automatic logic [15:0] get_val(input bit sel);
    return sel ? fp_bus.max_value : fx_bus.max_value;
  endfunction

  // Ordering key: signed value, or signed magnitude for binary16 (-0 maps to 0).
  function automatic int order_key(input bit fp, input logic [15:0] v);
    if (!fp) return int'($signed(v));
    if (v[15]) return -int'({17'b0, v[14:0]});
    return int'({17'b0, v[14:0]});
  endfunction

  function automatic exp_t model(input bit fp, input vec_t d);
    int best;
    exp_t e;
    best = 0;
    for (int i = 1; i < 10; i++)
      if (order_key(fp, d[i]) > order_key(fp, d[best])) best = i;
    e.idx = 4'(best);
    e.val = d[best];
    return e;
  endfunction

  task automatic set_data(input vec_t d);
    fx_bus.Data_in_1 = d[0]; fx_bus.Data_in_2 = d[1]; fx_bus.Data_in_3 = d[2];
    fx_bus.Data_in_4 = d[3]; fx_bus.Data_in_5 = d[4]; fx_bus.Data_in_6 = d[5];
    fx_bus.Data_in_7 = d[6]; fx_bus.Data_in_8 = d[7]; fx_bus.Data_in_9 = d[8];
    fx_bus.Data_in_10 = d[9];
    fp_bus.Data_in_1 = d[0]; fp_bus.Data_in_2 = d[1]; fp_bus.Data_in_3 = d[2];
    fp_bus.Data_in_4 = d[3]; fp_bus.Data_in_5 = d[4]; fp_bus.Data_in_6 = d[5];
    fp_bus.Data_in_7 = d[6]; fp_bus.Data_in_8 = d[7]; fp_bus.Data_in_9 = d[8];
    fp_bus.Data_in_10 = d[9];
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) fp_bus.start = v; else fx_bus.start = v;
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) fp_bus.res_ready = v; else fx_bus.res_ready = v;
  endtask

  // Returns after the start edge (E0) plus 1 time unit.
  task automatic launch(input bit sel, input vec_t d);
    @(negedge clk);
    set_data(d);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
  endtask

  task automatic wait_valid(input bit sel, output int cyc);
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (get_valid(sel)) begin
        cyc = n;
        return;
      end
    end
  endtask

  task automatic accept(input bit sel);
    @(negedge clk);
    set_ready(sel, 1'b1);
    @(posedge clk);
    #1;
    set_ready(sel, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      total += 4;
      if (get_busy(s[0]) !== 1'b0) begin bad++; $display("FAIL reset_busy sel=%0d got=%b exp=0", s, get_busy(s[0])); end
      if (get_valid(s[0]) !== 1'b0) begin bad++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, get_valid(s[0])); end
      if (get_idx(s[0]) !== 4'd0) begin bad++; $display("FAIL reset_idx sel=%0d got=%0d exp=0", s, get_idx(s[0])); end
      if (get_val(s[0]) !== 16'h0) begin bad++; $display("FAIL reset_val sel=%0d got=%h exp=0000", s, get_val(s[0])); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    vec_t d;
    exp_t e;
    int   cyc;
    d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    launch(1'b0, d);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total += 2;
    if (fx_bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", fx_bus.busy); end
    if (fx_bus.res_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", fx_bus.res_valid); end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    total += 2;
    if (fx_bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_idle_busy got=%b exp=0", fx_bus.busy); end
    if (fx_bus.res_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_result got=%b exp=0", fx_bus.res_valid); end
    d = '{16'd4, 16'd40, 16'd3, 16'd2, 16'd1, 16'd0, 16'd39, 16'd5, 16'd6, 16'd7};
    exp_q.push_back('{4'd1, 16'd40});
    launch(1'b0, d);
    wait_valid(1'b0, cyc);
    e = exp_q.pop_front();
    total += 3;
    if (cyc !== 9) begin bad++; $display("FAIL midreset_latency got=%0d exp=9", cyc); end
    if (fx_bus.class_idx !== e.idx) begin bad++; $display("FAIL midreset_idx got=%0d exp=%0d", fx_bus.class_idx, e.idx); end
    if (fx_bus.max_value !== e.val) begin bad++; $display("FAIL midreset_val got=%h exp=%h", fx_bus.max_value, e.val); end
    accept(1'b0);
  endtask

  task automatic test_fixed_basic();
    vec_t d [3];
    exp_t e;
    int   cyc;
    d[0] = '{16'd3, -16'sd7, 16'd12, 16'd0, 16'd5, 16'd12, -16'sd1, 16'd8, 16'd2, 16'd11};
    d[1] = '{-16'sd5, -16'sd3, -16'sd9, -16'sd3, -16'sd20, -16'sd8, -16'sd4, -16'sd6, -16'sd7, -16'sd30};
    d[2] = '{default: 16'h8000};
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: exp_q.push_back('{4'd2, 16'd12});
        1: exp_q.push_back('{4'd1, 16'hFFFD});
        default: exp_q.push_back('{4'd0, 16'h8000});
      endcase
      launch(1'b0, d[t]);
      wait_valid(1'b0, cyc);
      e = exp_q.pop_front();
      total += 3;
      if (cyc !== 9) begin bad++; $display("FAIL fixed_latency t=%0d got=%0d exp=9", t, cyc); end
      if (fx_bus.class_idx !== e.idx) begin bad++; $display("FAIL fixed_idx t=%0d got=%0d exp=%0d", t, fx_bus.class_idx, e.idx); end
      if (fx_bus.max_value !== e.val) begin bad++; $display("FAIL fixed_val t=%0d got=%h exp=%h", t, fx_bus.max_value, e.val); end
      accept(1'b0);
    end
  endtask

  task automatic test_snapshot_backpressure();
    vec_t d;
    vec_t junk;
    exp_t e;
    int   cyc;
    d    = '{16'd1, 16'd2, 16'd3, 16'd100, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    junk = '{default: 16'h7FFF};
    exp_q.push_back('{4'd3, 16'd100});
    launch(1'b0, d);
    set_data(junk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    fx_bus.start = 1'b1;
    @(posedge clk);
    #1;
    fx_bus.start = 1'b0;
    total += 1;
    if (fx_bus.busy !== 1'b1) begin bad++; $display("FAIL snap_busy_scan got=%b exp=1", fx_bus.busy); end
    wait_valid(1'b0, cyc);
    e = exp_q.pop_front();
    total += 1;
    if (cyc + 4 !== 9) begin bad++; $display("FAIL snap_latency got=%0d exp=9", cyc + 4); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fx_bus.start = k[0];
      @(posedge clk);
      #1;
      total += 3;
      if (fx_bus.res_valid !== 1'b1) begin bad++; $display("FAIL hold_valid k=%0d got=%b exp=1", k, fx_bus.res_valid); end
      if (fx_bus.class_idx !== e.idx) begin bad++; $display("FAIL hold_idx k=%0d got=%0d exp=%0d", k, fx_bus.class_idx, e.idx); end
      if (fx_bus.max_value !== e.val) begin bad++; $display("FAIL hold_val k=%0d got=%h exp=%h", k, fx_bus.max_value, e.val); end
    end
    fx_bus.start = 1'b0;
    accept(1'b0);
    @(posedge clk);
    #1;
    total += 3;
    if (fx_bus.busy !== 1'b0) begin bad++; $display("FAIL snap_idle_busy got=%b exp=0", fx_bus.busy); end
    if (fx_bus.class_idx !== e.idx) begin bad++; $display("FAIL idle_keep_idx got=%0d exp=%0d", fx_bus.class_idx, e.idx); end
    if (fx_bus.max_value !== e.val) begin bad++; $display("FAIL idle_keep_val got=%h exp=%h", fx_bus.max_value, e.val); end
  endtask

  task automatic test_binary16();
    vec_t d [2];
    exp_t e;
    int   cyc;
    d[0] = '{16'h8000, 16'h0000, 16'hC000, 16'h3C00, 16'h4200,
             16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00};
    d[1] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000,
             16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      if (t == 0) exp_q.push_back('{4'd4, 16'h4200});
      else        exp_q.push_back('{4'd0, 16'h8000});
      launch(1'b1, d[t]);
      wait_valid(1'b1, cyc);
      e = exp_q.pop_front();
      total += 3;
      if (cyc !== 9) begin bad++; $display("FAIL fp_latency t=%0d got=%0d exp=9", t, cyc); end
      if (fp_bus.class_idx !== e.idx) begin bad++; $display("FAIL fp_idx t=%0d got=%0d exp=%0d", t, fp_bus.class_idx, e.idx); end
      if (fp_bus.max_value !== e.val) begin bad++; $display("FAIL fp_val t=%0d got=%h exp=%h", t, fp_bus.max_value, e.val); end
      accept(1'b1);
    end
  endtask

  task automatic test_back_to_back();
    vec_t d1;
    vec_t d2;
    exp_t e;
    int   cyc;
    d1 = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    d2 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd50};
    exp_q.push_back('{4'd0, 16'd9});
    launch(1'b0, d1);
    wait_valid(1'b0, cyc);
    e = exp_q.pop_front();
    total += 2;
    if (fx_bus.class_idx !== e.idx) begin bad++; $display("FAIL b2b_first_idx got=%0d exp=%0d", fx_bus.class_idx, e.idx); end
    if (fx_bus.max_value !== e.val) begin bad++; $display("FAIL b2b_first_val got=%h exp=%h", fx_bus.max_value, e.val); end
    @(negedge clk);
    set_data(d2);
    fx_bus.res_ready = 1'b1;
    fx_bus.start     = 1'b1;
    @(posedge clk);
    #1;
    fx_bus.res_ready = 1'b0;
    fx_bus.start     = 1'b0;
    @(posedge clk);
    #1;
    total += 2;
    if (fx_bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_no_run_busy got=%b exp=0", fx_bus.busy); end
    if (fx_bus.res_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_run_valid got=%b exp=0", fx_bus.res_valid); end
    exp_q.push_back('{4'd9, 16'd50});
    launch(1'b0, d2);
    wait_valid(1'b0, cyc);
    e = exp_q.pop_front();
    total += 3;
    if (cyc !== 9) begin bad++; $display("FAIL b2b_latency got=%0d exp=9", cyc); end
    if (fx_bus.class_idx !== e.idx) begin bad++; $display("FAIL b2b_second_idx got=%0d exp=%0d", fx_bus.class_idx, e.idx); end
    if (fx_bus.max_value !== e.val) begin bad++; $display("FAIL b2b_second_val got=%h exp=%h", fx_bus.max_value, e.val); end
    accept(1'b0);
  endtask

  task automatic test_random();
    vec_t d;
    exp_t e;
    int   cyc;
    for (int t = 0; t < 8; t++) begin
      bit fp;
      fp = t[0];
      for (int i = 0; i < 10; i++) begin
        d[i] = 16'($urandom);
        if (t[1]) d[i][15:4] = 12'h000;
        if (fp && d[i][14:10] == 5'h1f) d[i][14] = 1'b0;
      end
      exp_q.push_back(model(fp, d));
      launch(fp, d);
      wait_valid(fp, cyc);
      e = exp_q.pop_front();
      total += 3;
      if (cyc !== 9) begin bad++; $display("FAIL rand_latency t=%0d got=%0d exp=9", t, cyc); end
      if (get_idx(fp) !== e.idx) begin bad++; $display("FAIL rand_idx t=%0d got=%0d exp=%0d", t, get_idx(fp), e.idx); end
      if (get_val(fp) !== e.val) begin bad++; $display("FAIL rand_val t=%0d got=%h exp=%h", t, get_val(fp), e.val); end
      accept(fp);
    end
  endtask

  initial begin
    vec_t z;
    total = 0;
    bad   = 0;
    z     = '{default: 16'h0};
    reset = 1'b1;
    fx_bus.start = 1'b0; fx_bus.res_ready = 1'b0;
    fp_bus.start = 1'b0; fp_bus.res_ready = 1'b0;
    set_data(z);
    test_reset();
    test_reset_mid_run();
    test_fixed_basic();
    test_snapshot_backpressure();
    test_binary16();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
